// File: rtl/wbgpio_master.sv
// Wishbone pipelined initiator that mirrors a local output vector into a remote
// set/clear-mask GPIO register and periodically polls it for the remote inputs.
module wbgpio_master #(
    parameter int unsigned     NIN         = 16,
    parameter int unsigned     NOUT        = 16,
    parameter logic [NOUT-1:0] DEFAULT     = '0,
    parameter int unsigned     AW          = 30,
    parameter logic [AW-1:0]   GPIO_ADDR   = '0,
    parameter int unsigned     POLL_CYCLES = 1024,
    parameter int unsigned     TIMEOUT     = 255
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [NOUT-1:0] i_out,
    output logic [NIN-1:0]  o_in,
    output logic            o_in_valid,
    output logic            o_int,
    output logic            o_err,
    output logic            o_busy,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [31:0]     o_wb_data,
    output logic [3:0]      o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic [31:0]     i_wb_data,
    input  logic            i_wb_err
);

    localparam int unsigned PW = $clog2(POLL_CYCLES);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREQ,
        S_WACK,
        S_RREQ,
        S_RACK
    } state_t;

    state_t          state_q;
    logic            cyc_q;
    logic            stb_q;
    logic            we_q;
    logic [31:0]     wdata_q;
    logic [NOUT-1:0] sent_q;
    logic [NOUT-1:0] wval_q;
    logic [NIN-1:0]  in_q;
    logic            in_valid_q;
    logic            int_q;
    logic            err_q;
    logic [PW-1:0]   poll_q;
    logic            rd_pend_q;
    logic [TW-1:0]   tmo_q;

    logic            ack_state_c;
    logic            tmo_hit_c;
    logic            abort_c;
    logic            rd_done_c;
    logic [NIN-1:0]  rd_new_c;
    logic [NOUT-1:0] mask_c;
    logic            unused_c;

    assign ack_state_c = (state_q == S_WACK) || (state_q == S_RACK);
    assign tmo_hit_c   = (tmo_q == TW'(TIMEOUT - 1));
    // An error only counts once the request is on the bus: while waiting for the
    // response, or while the strobe is still being stalled.
    assign abort_c     = tmo_hit_c || (i_wb_err && (ack_state_c || i_wb_stall));
    assign rd_done_c   = (state_q == S_RACK) && i_wb_ack;
    assign rd_new_c    = i_wb_data[16 +: NIN];
    assign mask_c      = i_out ^ sent_q;
    assign unused_c    = ^i_wb_data;

    // Free-running poll timer; a new poll request wins over a read completing on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            poll_q    <= PW'(POLL_CYCLES - 1);
            rd_pend_q <= 1'b0;
        end else if (poll_q == '0) begin
            poll_q    <= PW'(POLL_CYCLES - 1);
            rd_pend_q <= 1'b1;
        end else begin
            poll_q <= poll_q - PW'(1);
            if (rd_done_c) begin
                rd_pend_q <= 1'b0;
            end
        end
    end

    // Transaction FSM with registered bus and status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            sent_q     <= DEFAULT;
            wval_q     <= DEFAULT;
            in_q       <= '0;
            in_valid_q <= 1'b0;
            int_q      <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            int_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tmo_q <= '0;
                    if (i_out != sent_q) begin
                        state_q <= S_WREQ;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        wval_q  <= i_out;
                        wdata_q <= {16'(mask_c), 16'(i_out)};
                    end else if (rd_pend_q) begin
                        state_q <= S_RREQ;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b0;
                    end
                end
                S_WREQ, S_WACK, S_RREQ, S_RACK: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (ack_state_c && i_wb_ack) begin
                        state_q <= S_IDLE;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        if (state_q == S_WACK) begin
                            sent_q <= wval_q;
                        end else begin
                            in_q       <= rd_new_c;
                            in_valid_q <= 1'b1;
                            int_q      <= in_valid_q && (rd_new_c != in_q);
                        end
                    end else if (abort_c) begin
                        state_q <= S_IDLE;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (!ack_state_c && !i_wb_stall) begin
                        stb_q   <= 1'b0;
                        state_q <= (state_q == S_WREQ) ? S_WACK : S_RACK;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign o_in       = in_q;
    assign o_in_valid = in_valid_q;
    assign o_int      = int_q;
    assign o_err      = err_q;
    assign o_busy     = cyc_q;
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_we    = we_q;
    assign o_wb_addr  = GPIO_ADDR;
    assign o_wb_data  = wdata_q;
    assign o_wb_sel   = 4'hf;

endmodule
